// File: rtl/gcd_pkg.sv
// gcd_pkg
// Shared definitions for the GCD unit and its operand queue.
//   GCD_WL        default operand word length in bits
//   GCD_DEPTH     default operand queue capacity in pairs
//   operand_pair_t  one {a, b} operand pair as handed to the GCD unit
package gcd_pkg;

   localparam int GCD_WL    = 8;
   localparam int GCD_DEPTH = 4;

   typedef struct packed {
      logic [GCD_WL-1:0] a;
      logic [GCD_WL-1:0] b;
   } operand_pair_t;

endpackage

// File: rtl/gcd_ops_fifo.sv
// gcd_ops_fifo
// Operand-pair queue placed in front of the GCD unit. The producer pushes
// {in_a, in_b} with a valid/ready handshake and the GCD unit pops the head
// pair with a second valid/ready handshake. Both ready and valid come only
// from registered state, so neither side sees a combinational path from the
// other.
// Ports:
//   clk      single clock, rising edge
//   rst      asynchronous active-high reset
//   in_val   producer offers a pair          in_rdy   queue has room
//   in_a     operand A from producer         in_b     operand B from producer
//   ops_val  head pair valid                 ops_rdy  GCD unit takes head pair
//   ops_a    head operand A                  ops_b    head operand B
//   count    number of stored pairs (0..DEPTH)
module gcd_ops_fifo
   import gcd_pkg::*;
#(
   parameter int WL    = GCD_WL,
   parameter int DEPTH = GCD_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_val,
   output logic                       in_rdy,
   input  logic [WL-1:0]              in_a,
   input  logic [WL-1:0]              in_b,
   output logic                       ops_val,
   input  logic                       ops_rdy,
   output logic [WL-1:0]              ops_a,
   output logic [WL-1:0]              ops_b,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   operand_pair_t mem [DEPTH];
   operand_pair_t wr_pair;
   operand_pair_t head_pair;

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic          push;
   logic          pop;

   // Flags depend only on count_q, so in_rdy never depends on ops_rdy and
   // ops_val never depends on in_val.
   assign in_rdy  = (count_q != CW'(DEPTH));
   assign ops_val = (count_q != '0);
   assign push    = in_val && in_rdy;
   assign pop     = ops_val && ops_rdy;
   assign count   = count_q;

   // The package pair type has a fixed field width; casts adapt it to WL.
   assign wr_pair.a = GCD_WL'(in_a);
   assign wr_pair.b = GCD_WL'(in_b);

   assign head_pair = mem[rd_ptr];
   assign ops_a     = WL'(head_pair.a);
   assign ops_b     = WL'(head_pair.b);

   // Storage carries no reset; the pointers and count alone decide validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_pair;
      end
   end

   // DEPTH is a power of two, so the pointers wrap from DEPTH-1 to 0 by
   // natural overflow. A simultaneous push and pop leaves count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_ops_fifo.sv
// tb_gcd_ops_fifo
// Self-checking bench for gcd_ops_fifo. Inputs are driven on the falling
// edge, outputs are sampled 1 time unit later, and a reference queue holds
// every pair accepted so far; each pop is compared against its front.
module tb_gcd_ops_fifo;

   localparam int WL    = 8;
   localparam int DEPTH = 4;

   typedef struct {
      logic [WL-1:0] a;
      logic [WL-1:0] b;
   } pair_t;

   logic          clk;
   logic          rst;
   logic          in_val;
   logic          in_rdy;
   logic [WL-1:0] in_a;
   logic [WL-1:0] in_b;
   logic          ops_val;
   logic          ops_rdy;
   logic [WL-1:0] ops_a;
   logic [WL-1:0] ops_b;
   logic [2:0]    count;

   pair_t sb [$];
   int    checks;
   int    errors;

   gcd_ops_fifo #(.WL(WL), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .in_val  (in_val),
      .in_rdy  (in_rdy),
      .in_a    (in_a),
      .in_b    (in_b),
      .ops_val (ops_val),
      .ops_rdy (ops_rdy),
      .ops_a   (ops_a),
      .ops_b   (ops_b),
      .count   (count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   // One clock cycle: drive on the falling edge, compare flags against the
   // reference queue, then update the queue for whichever handshakes fire.
   task automatic applyStimulus(input logic v, input logic [WL-1:0] a,
                                input logic [WL-1:0] b, input logic r);
      logic  exp_rdy;
      logic  exp_val;
      pair_t head;
      pair_t nw;
      @(negedge clk);
      in_val  = v;
      in_a    = a;
      in_b    = b;
      ops_rdy = r;
      #1;
      exp_rdy = (sb.size() < DEPTH);
      exp_val = (sb.size() != 0);
      checkOutput("in_rdy", 32'(in_rdy), 32'(exp_rdy));
      checkOutput("ops_val", 32'(ops_val), 32'(exp_val));
      checkOutput("count", 32'(count), 32'(sb.size()));
      if (exp_val && r) begin
         head = sb.pop_front();
         checkOutput("pop_a", 32'(ops_a), 32'(head.a));
         checkOutput("pop_b", 32'(ops_b), 32'(head.b));
      end
      if (v && exp_rdy) begin
         nw.a = a;
         nw.b = b;
         sb.push_back(nw);
      end
   endtask

   // Idle cycle with explicit constant expectations on the head and count.
   task automatic checkHead(input logic [WL-1:0] ea, input logic [WL-1:0] eb,
                            input int ecount);
      @(negedge clk);
      in_val  = 1'b0;
      ops_rdy = 1'b0;
      #1;
      checkOutput("head_val", 32'(ops_val), 32'd1);
      checkOutput("head_a", 32'(ops_a), 32'(ea));
      checkOutput("head_b", 32'(ops_b), 32'(eb));
      checkOutput("head_count", 32'(count), 32'(ecount));
      checkOutput("head_in_rdy", 32'(in_rdy), (ecount != DEPTH) ? 32'd1 : 32'd0);
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         applyStimulus(1'b0, '0, '0, 1'b1);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst     = 1'b1;
      in_val  = 1'b0;
      in_a    = '0;
      in_b    = '0;
      ops_rdy = 1'b0;
      #1;
      checkOutput("rst_in_rdy", 32'(in_rdy), 32'd1);
      checkOutput("rst_ops_val", 32'(ops_val), 32'd0);
      checkOutput("rst_count", 32'(count), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Single push into empty queue shows up as the head next cycle.
      applyStimulus(1'b1, 8'd12, 8'd18, 1'b0);
      checkHead(8'd12, 8'd18, 1);
      drain(2);

      // Fill to capacity, reject a fifth push, then drain in order.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 8'(2 * i + 1), 8'(2 * i + 2), 1'b0);
      end
      checkHead(8'd1, 8'd2, 4);
      applyStimulus(1'b1, 8'd9, 8'd9, 1'b0);
      checkHead(8'd1, 8'd2, 4);
      drain(5);

      // Steady-state streaming at count=2 across pointer wrap.
      applyStimulus(1'b1, 8'd40, 8'd41, 1'b0);
      applyStimulus(1'b1, 8'd42, 8'd43, 1'b0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 8'(50 + i), 8'(60 + i), 1'b1);
      end
      checkHead(8'd54, 8'd64, 2);

      // Full queue with pop and push on the same edge: only the pop lands.
      applyStimulus(1'b1, 8'd70, 8'd71, 1'b0);
      applyStimulus(1'b1, 8'd72, 8'd73, 1'b0);
      applyStimulus(1'b1, 8'd99, 8'd99, 1'b1);
      checkHead(8'd55, 8'd65, 3);

      // Asynchronous reset between edges with three pairs stored.
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checkOutput("async_ops_val", 32'(ops_val), 32'd0);
      checkOutput("async_in_rdy", 32'(in_rdy), 32'd1);
      checkOutput("async_count", 32'(count), 32'd0);
      #1 rst = 1'b0;
      sb.delete();
      applyStimulus(1'b1, 8'd0, 8'd5, 1'b0);
      checkHead(8'd0, 8'd5, 1);
      drain(2);

      // Random traffic against the reference queue.
      for (int i = 0; i < 1000; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                       1'($urandom_range(0, 1)));
         if (count > 3'(DEPTH)) begin
            checkOutput("count_max", 32'(count), 32'(DEPTH));
         end
      end
      drain(DEPTH + 2);
      checkOutput("sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
